// File: rtl/data_mem_responder.sv
// Purpose: M-stage data memory responder: captures a CPU access, services it from a word RAM, and acks.
// Latency: the capture edge is followed by WAIT_CYCLES wait states, then a one-cycle registered ack.
// Backpressure: the CPU holds mem_req_M until ack; one access in flight, spaced WAIT_CYCLES+2 cycles apart.
module data_mem_responder #(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req_M,
    input  logic        mem_write_M,
    input  logic [31:0] alu_out_M,
    input  logic [31:0] write_data_M,
    input  logic [3:0]  byte_en_M,
    output logic [31:0] read_data_M,
    output logic        data_mem_ack_M,
    output logic        data_mem_err_M
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t          state_q, state_nxt;
    logic [CW-1:0]   cnt_q, cnt_nxt;
    logic            capture;

    logic            cap_write;
    logic [31:0]     cap_addr;
    logic [31:0]     cap_wdat;
    logic [3:0]      cap_ben;

    logic [31:0]     mem [0:(1 << ADDR_WIDTH) - 1];

    // With zero wait states the access completes on its own capture edge,
    // so the live CPU inputs stand in for the not-yet-loaded captured copy.
    logic            use_live;
    logic            eff_write;
    logic [31:0]     eff_addr;
    logic [31:0]     eff_wdat;
    logic [3:0]      eff_ben;
    logic [32:0]     offset;
    logic            in_range;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0]     old_word;
    logic [31:0]     new_word;
    logic            enter_ack;
    logic [1:0]      unused_offset_lsb;

    // Next-state and wait-counter logic
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        capture   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_req_M) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = S_ACK;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) state_nxt = S_ACK;
                else             cnt_nxt   = cnt_q - 1'b1;
            end
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Address decode and byte-lane merge for the access being completed
    always_comb begin
        use_live  = (state_q == S_IDLE);
        eff_write = use_live ? mem_write_M  : cap_write;
        eff_addr  = use_live ? alu_out_M    : cap_addr;
        eff_wdat  = use_live ? write_data_M : cap_wdat;
        eff_ben   = use_live ? byte_en_M    : cap_ben;
        offset    = {1'b0, eff_addr} - {1'b0, BASE_ADDR};
        in_range  = !offset[32] && (offset[31:ADDR_WIDTH+2] == '0);
        word_idx  = offset[ADDR_WIDTH+1:2];
        unused_offset_lsb = offset[1:0];
        old_word  = mem[word_idx];
        new_word  = old_word;
        for (int i = 0; i < 4; i++) begin
            if (eff_write && eff_ben[i]) new_word[8*i +: 8] = eff_wdat[8*i +: 8];
        end
        // Gated by reset so nothing completes while reset is held
        enter_ack = reset && (state_nxt == S_ACK) && (state_q != S_ACK);
    end

    // FSM state, counter and captured request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            cap_write <= 1'b0;
            cap_addr  <= '0;
            cap_wdat  <= '0;
            cap_ben   <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            if (capture) begin
                cap_write <= mem_write_M;
                cap_addr  <= alu_out_M;
                cap_wdat  <= write_data_M;
                cap_ben   <= byte_en_M;
            end
        end
    end

    // Registered response: ack/err pulse and read data held until the next ack
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_data_M    <= '0;
            data_mem_ack_M <= 1'b0;
            data_mem_err_M <= 1'b0;
        end else begin
            data_mem_ack_M <= enter_ack;
            data_mem_err_M <= enter_ack && !in_range;
            if (enter_ack) read_data_M <= in_range ? new_word : 32'h0;
        end
    end

    // RAM write on the edge entering ACK; contents are never reset
    always_ff @(posedge clk) begin
        if (enter_ack && eff_write && in_range) mem[word_idx] <= new_word;
    end

endmodule
